// File: rtl/fir_pkg.sv
// Shared types and arithmetic helpers for the serial-MAC FIR filter.
package fir_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, MAC, OUT} state_t;

  typedef struct packed {
    logic               sat;
    logic signed [63:0] val;
  } rs_t;

  // Accumulator wide enough to sum NUM_TAPS full-scale products without overflow.
  function automatic int unsigned acc_w(int unsigned dw, int unsigned cw, int unsigned nt);
    return dw + cw + $clog2(nt);
  endfunction

  // Reset coefficients form the identity filter: h[0] = 1.0, all others zero.
  function automatic logic signed [63:0] coef_init(int unsigned k, int unsigned frac_w);
    return (k == 0) ? (64'sd1 <<< frac_w) : 64'sd0;
  endfunction

  function automatic rs_t round_sat(logic signed [63:0] acc, int unsigned frac_w,
                                    int unsigned data_w);
    logic signed [63:0] r;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    rs_t                o;
    r  = (acc + (64'sd1 <<< (frac_w - 1))) >>> frac_w;
    hi = (64'sd1 <<< (data_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (data_w - 1));
    if (r > hi) begin
      o.sat = 1'b1;
      o.val = hi;
    end else if (r < lo) begin
      o.sat = 1'b1;
      o.val = lo;
    end else begin
      o.sat = 1'b0;
      o.val = r;
    end
    return o;
  endfunction

endpackage

// File: rtl/fir_mac_sat.sv
// Registered multiply-accumulate with half-up rounding and output saturation.
module fir_mac_sat
  import fir_pkg::*;
#(
  parameter int unsigned DATA_W = 18,
  parameter int unsigned COEF_W = 18,
  parameter int unsigned FRAC_W = 15,
  parameter int unsigned ACC_W  = 40
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     clear_i,
  input  logic                     en_i,
  input  logic signed [DATA_W-1:0] x_i,
  input  logic signed [COEF_W-1:0] h_i,
  output logic signed [DATA_W-1:0] y_o,
  output logic                     sat_o
);

  localparam int unsigned PROD_W = DATA_W + COEF_W;

  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [PROD_W-1:0] prod;
  rs_t                      rs;

  always_comb begin
    prod  = PROD_W'(x_i) * PROD_W'(h_i);
    acc_d = acc_q;
    if (clear_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = acc_q + ACC_W'(prod);
    end
    rs    = round_sat(64'(acc_q), FRAC_W, DATA_W);
    y_o   = rs.val[DATA_W-1:0];
    sat_o = rs.sat;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/fir_serial_mac.sv
// Multi-channel serial-MAC FIR: one tap per clock over per-channel delay lines
// sharing a runtime-loadable coefficient set.
module fir_serial_mac
  import fir_pkg::*;
#(
  parameter int unsigned DATA_W   = 18,
  parameter int unsigned COEF_W   = 18,
  parameter int unsigned FRAC_W   = 15,
  parameter int unsigned NUM_TAPS = 16,
  parameter int unsigned NUM_CH   = 1,
  localparam int unsigned CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int unsigned K_W     = $clog2(NUM_TAPS)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     stf_i,
  input  logic [CH_W-1:0]          ch_i,
  input  logic signed [DATA_W-1:0] xn_i,
  input  logic                     coef_we_i,
  input  logic [K_W-1:0]           coef_addr_i,
  input  logic signed [COEF_W-1:0] coef_data_i,
  output logic                     busy_o,
  output logic signed [DATA_W-1:0] y_o,
  output logic [CH_W-1:0]          ch_o,
  output logic                     eof_o,
  output logic                     sat_o
);

  localparam int unsigned ACC_W = acc_w(DATA_W, COEF_W, NUM_TAPS);

  state_t                   state_q, state_d;
  logic [K_W-1:0]           k_q, k_d;
  logic signed [DATA_W-1:0] xin_q, xin_d;
  logic [CH_W-1:0]          ch_q, ch_d;
  logic signed [DATA_W-1:0] x_q [NUM_CH][NUM_TAPS];
  logic signed [DATA_W-1:0] x_d [NUM_CH][NUM_TAPS];
  logic signed [COEF_W-1:0] h_q [NUM_TAPS];
  logic signed [COEF_W-1:0] h_d [NUM_TAPS];
  logic signed [DATA_W-1:0] y_q, y_d;
  logic [CH_W-1:0]          cho_q, cho_d;
  logic                     sat_q, sat_d;
  logic                     eof_q, eof_d;
  logic                     busy_q, busy_d;

  logic                     mac_clr, mac_en, mac_sat;
  logic signed [DATA_W-1:0] mac_x, mac_y;
  logic signed [COEF_W-1:0] mac_h;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    xin_d   = xin_q;
    ch_d    = ch_q;
    x_d     = x_q;
    h_d     = h_q;
    y_d     = y_q;
    cho_d   = cho_q;
    sat_d   = sat_q;
    eof_d   = 1'b0;
    busy_d  = busy_q;
    mac_clr = 1'b0;
    mac_en  = 1'b0;
    mac_x   = x_q[ch_q][k_q];
    mac_h   = h_q[k_q];

    unique case (state_q)
      IDLE: begin
        // The first IDLE cycle is the eof cycle; busy drops after it unless restarted.
        busy_d = 1'b0;
        if (coef_we_i) h_d[coef_addr_i] = coef_data_i;
        if (stf_i && (32'(ch_i) < NUM_CH)) begin
          xin_d   = xn_i;
          ch_d    = ch_i;
          busy_d  = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        for (int unsigned i = NUM_TAPS - 1; i > 0; i--) begin
          x_d[ch_q][i] = x_q[ch_q][i-1];
        end
        x_d[ch_q][0] = xin_q;
        mac_clr      = 1'b1;
        k_d          = '0;
        state_d      = MAC;
      end
      MAC: begin
        mac_en = 1'b1;
        k_d    = k_q + 1'b1;
        if (k_q == K_W'(NUM_TAPS - 1)) state_d = OUT;
      end
      OUT: begin
        y_d     = mac_y;
        sat_d   = mac_sat;
        cho_d   = ch_q;
        eof_d   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      k_q     <= '0;
      xin_q   <= '0;
      ch_q    <= '0;
      x_q     <= '{default: '0};
      for (int unsigned i = 0; i < NUM_TAPS; i++) begin
        h_q[i] <= COEF_W'(coef_init(i, FRAC_W));
      end
      y_q     <= '0;
      cho_q   <= '0;
      sat_q   <= 1'b0;
      eof_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      xin_q   <= xin_d;
      ch_q    <= ch_d;
      x_q     <= x_d;
      h_q     <= h_d;
      y_q     <= y_d;
      cho_q   <= cho_d;
      sat_q   <= sat_d;
      eof_q   <= eof_d;
      busy_q  <= busy_d;
    end
  end

  fir_mac_sat #(
    .DATA_W(DATA_W),
    .COEF_W(COEF_W),
    .FRAC_W(FRAC_W),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clear_i(mac_clr),
    .en_i   (mac_en),
    .x_i    (mac_x),
    .h_i    (mac_h),
    .y_o    (mac_y),
    .sat_o  (mac_sat)
  );

  assign busy_o = busy_q;
  assign y_o    = y_q;
  assign ch_o   = cho_q;
  assign eof_o  = eof_q;
  assign sat_o  = sat_q;

endmodule
